// File: rtl/lpc_sniffer_pkg.sv
// Shared constants and decoder state encoding for the LPC bus sniffer.
package lpc_sniffer_pkg;

    localparam logic [1:0] CYC_IO          = 2'b00;
    localparam logic [1:0] CYC_MEM         = 2'b01;

    localparam logic [3:0] SYNC_READY      = 4'h0;
    localparam logic [3:0] SYNC_WAIT_SHORT = 4'h5;
    localparam logic [3:0] SYNC_WAIT_LONG  = 4'h6;

    localparam logic [7:0] HDR_BASE        = 8'hA0;
    localparam int         RECORD_W        = 48;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_W_DATA,
        ST_TAR1,
        ST_TAR2,
        ST_SYNC,
        ST_R_DATA,
        ST_DONE
    } dec_state_t;

endpackage

// File: rtl/lpc_sniffer_uart_tx.sv
// 8N1 transmitter, LSB first, DIV clocks per bit. A new byte offered during the
// last clock of a stop bit is taken immediately, so bytes can run back to back.
module uart_tx #(
    parameter int DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_tx
);
    localparam int CW = $clog2(DIV);

    logic          r_busy;
    logic [9:0]    r_shift;
    logic [CW-1:0] r_baud;
    logic [3:0]    r_bits;
    logic          w_baud_tc;
    logic          w_last;

    assign w_baud_tc = (r_baud == '0);
    assign w_last    = (r_bits == 4'd1);
    assign o_ready   = !r_busy || (w_baud_tc && w_last);
    assign o_busy    = r_busy;
    assign o_tx      = r_busy ? r_shift[0] : 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_shift <= '1;
            r_baud  <= '0;
            r_bits  <= 4'd0;
        end else if (i_valid && o_ready) begin
            r_busy  <= 1'b1;
            r_shift <= {1'b1, i_data, 1'b0};
            r_baud  <= CW'(DIV - 1);
            r_bits  <= 4'd10;
        end else if (r_busy) begin
            if (w_baud_tc) begin
                r_baud  <= CW'(DIV - 1);
                r_shift <= {1'b1, r_shift[9:1]};
                r_bits  <= r_bits - 4'd1;
                if (w_last) r_busy <= 1'b0;
            end else begin
                r_baud <= r_baud - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lpc_sniffer_top.sv
// Passive LPC sniffer: decodes host I/O and memory cycles into 48-bit records,
// buffers them in a FIFO and streams each record as six UART bytes.
module lpc_sniffer_top
    import lpc_sniffer_pkg::*;
#(
    parameter int CLOCK_FREQ = 4800,
    parameter int BAUD_RATE  = 1200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       lpc_clock,
    input  logic       lpc_reset,
    input  logic       ext_clock,
    input  logic [3:0] lpc_ad,
    input  logic       lpc_frame,
    output logic       uart_tx_pin,
    output logic       lpc_clock_led,
    output logic       lpc_frame_led,
    output logic       lpc_reset_led,
    output logic       uart_tx_led,
    output logic       overflow_led
);
    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);

    dec_state_t          r_state, w_next;
    logic [1:0]          r_type;
    logic                r_dir;
    logic [31:0]         r_addr;
    logic [7:0]          r_data;
    logic [3:0]          r_nib;
    logic                w_nib_tc;
    logic                w_push;
    logic [RECORD_W-1:0] w_record;

    logic [RECORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr, r_rd_ptr;
    logic                w_empty, w_full, w_pop, w_push_ok;
    logic                r_overflow;

    logic [RECORD_W-1:0] r_rec;
    logic [2:0]          r_ser_left;
    logic                r_ser_active;
    logic                w_tx_ready, w_tx_busy;

    logic [22:0]         r_hb_cnt;
    logic                r_frame_led;
    logic                w_unused;

    assign w_unused = ext_clock;
    assign w_nib_tc = (r_nib == 4'd1);

    // Decoder: state register and next-state logic.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            ST_IDLE:    if (!lpc_frame && lpc_ad == 4'h0) w_next = ST_CYCTYPE;
            ST_CYCTYPE: begin
                if (!lpc_frame)
                    w_next = (lpc_ad == 4'h0) ? ST_CYCTYPE : ST_IDLE;
                else if (lpc_ad[3:2] == CYC_IO || lpc_ad[3:2] == CYC_MEM)
                    w_next = ST_ADDR;
                else
                    w_next = ST_IDLE;
            end
            ST_ADDR:    if (w_nib_tc) w_next = r_dir ? ST_W_DATA : ST_TAR1;
            ST_W_DATA:  if (w_nib_tc) w_next = ST_TAR1;
            ST_TAR1:    w_next = ST_TAR2;
            ST_TAR2:    w_next = ST_SYNC;
            ST_SYNC: begin
                if (lpc_ad == SYNC_READY)
                    w_next = r_dir ? ST_DONE : ST_R_DATA;
                else if (lpc_ad != SYNC_WAIT_SHORT && lpc_ad != SYNC_WAIT_LONG)
                    w_next = ST_IDLE;
            end
            ST_R_DATA:  if (w_nib_tc) w_next = ST_DONE;
            ST_DONE: begin
                w_push = 1'b1;
                w_next = ST_IDLE;
            end
            default:    w_next = ST_IDLE;
        endcase
        // LFRAME# mid-cycle aborts; a START nibble on that edge begins a new cycle.
        if (!lpc_frame && r_state != ST_IDLE && r_state != ST_CYCTYPE)
            w_next = (lpc_ad == 4'h0) ? ST_CYCTYPE : ST_IDLE;
    end

    // Decoder datapath; data nibbles arrive low first, so shift in from the top.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_type <= 2'b00;
            r_dir  <= 1'b0;
            r_addr <= 32'h0;
            r_data <= 8'h0;
            r_nib  <= 4'd0;
        end else begin
            case (r_state)
                ST_CYCTYPE: if (lpc_frame) begin
                    r_type <= lpc_ad[3:2];
                    r_dir  <= lpc_ad[1];
                    r_nib  <= (lpc_ad[3:2] == CYC_MEM) ? 4'd8 : 4'd4;
                    r_addr <= 32'h0;
                end
                ST_ADDR: begin
                    r_addr <= {r_addr[27:0], lpc_ad};
                    r_nib  <= w_nib_tc ? 4'd2 : r_nib - 4'd1;
                end
                ST_W_DATA, ST_R_DATA: begin
                    r_data <= {lpc_ad, r_data[7:4]};
                    r_nib  <= r_nib - 4'd1;
                end
                ST_SYNC: r_nib <= 4'd2;
                default: ;
            endcase
        end
    end

    assign w_record = {HDR_BASE | {4'h0, r_type, r_dir, 1'b0}, r_addr, r_data};

    // Record FIFO; a pop in the same cycle frees the slot for a push when full.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !r_ser_active && !w_empty && !w_tx_busy;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge lpc_clock) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= w_record;
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    // Serializer: one record at a time, header byte first.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_rec        <= '0;
            r_ser_left   <= 3'd0;
            r_ser_active <= 1'b0;
        end else if (w_pop) begin
            r_rec        <= r_mem[r_rd_ptr[AW-1:0]];
            r_ser_left   <= 3'd6;
            r_ser_active <= 1'b1;
        end else if (r_ser_active && w_tx_ready) begin
            r_rec      <= {r_rec[RECORD_W-9:0], 8'h00};
            r_ser_left <= r_ser_left - 3'd1;
            if (r_ser_left == 3'd1) r_ser_active <= 1'b0;
        end
    end

    uart_tx #(.DIV(DIV)) u_uart_tx (
        .i_clk   (lpc_clock),
        .i_rst_n (lpc_reset),
        .i_valid (r_ser_active),
        .i_data  (r_rec[RECORD_W-1 -: 8]),
        .o_ready (w_tx_ready),
        .o_busy  (w_tx_busy),
        .o_tx    (uart_tx_pin)
    );

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_hb_cnt    <= 23'd0;
            r_frame_led <= 1'b0;
        end else begin
            r_hb_cnt    <= r_hb_cnt + 23'd1;
            r_frame_led <= ~lpc_frame;
        end
    end

    assign lpc_clock_led = r_hb_cnt[22];
    assign lpc_frame_led = r_frame_led;
    assign lpc_reset_led = ~lpc_reset;
    assign uart_tx_led   = w_tx_busy;
    assign overflow_led  = r_overflow;

endmodule

// File: tb/tb_lpc_sniffer_top.sv
// Randomized LPC cycle stimulus checked against a record/byte-queue model and a UART decoder.
module tb_lpc_sniffer_top;
    localparam int DIV = 4;

    logic       lpc_clock;
    logic       lpc_reset;
    logic       ext_clock;
    logic [3:0] lpc_ad;
    logic       lpc_frame;
    logic       uart_tx_pin;
    logic       lpc_clock_led;
    logic       lpc_frame_led;
    logic       lpc_reset_led;
    logic       uart_tx_led;
    logic       overflow_led;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ncyc     = 0;
    logic [7:0] exp_q[$];

    lpc_sniffer_top dut (
        .lpc_clock     (lpc_clock),
        .lpc_reset     (lpc_reset),
        .ext_clock     (ext_clock),
        .lpc_ad        (lpc_ad),
        .lpc_frame     (lpc_frame),
        .uart_tx_pin   (uart_tx_pin),
        .lpc_clock_led (lpc_clock_led),
        .lpc_frame_led (lpc_frame_led),
        .lpc_reset_led (lpc_reset_led),
        .uart_tx_led   (uart_tx_led),
        .overflow_led  (overflow_led)
    );

    initial lpc_clock = 1'b0;
    always #5 lpc_clock = ~lpc_clock;
    always @(posedge lpc_clock) ncyc++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a completed cycle becomes header, address MSB first, data.
    task automatic model_push(input logic [1:0] ty, input logic dir,
                              input logic [31:0] addr, input logic [7:0] data);
        exp_q.push_back(8'hA0 + 8'(ty) * 8'd4 + 8'(dir) * 8'd2);
        exp_q.push_back(addr[31:24]);
        exp_q.push_back(addr[23:16]);
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(data);
    endtask

    task automatic drive(input logic f, input logic [3:0] a);
        @(negedge lpc_clock);
        lpc_frame = f;
        lpc_ad    = a;
    endtask

    task automatic do_cycle(input logic [1:0] ty, input logic dir, input logic [31:0] addr,
                            input logic [7:0] data, input int nwait, input logic [3:0] sync,
                            input bit abort_addr);
        int n;
        n = (ty == 2'b01) ? 8 : 4;
        drive(1'b0, 4'h0);
        drive(1'b1, {ty, dir, 1'b0});
        for (int i = n - 1; i >= 0; i--) begin
            if (abort_addr && i == n - 3) begin
                drive(1'b0, 4'hF);
                drive(1'b1, 4'hF);
                return;
            end
            drive(1'b1, addr[4*i +: 4]);
        end
        if (dir) begin
            drive(1'b1, data[3:0]);
            drive(1'b1, data[7:4]);
        end
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        for (int w = 0; w < nwait; w++)
            drive(1'b1, ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6);
        drive(1'b1, sync);
        if (sync != 4'h0) begin
            drive(1'b1, 4'hF);
            return;
        end
        if (!dir) begin
            drive(1'b1, data[3:0]);
            drive(1'b1, data[7:4]);
        end
        drive(1'b1, 4'hF);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || uart_tx_led) && n < 6000) begin
            @(posedge lpc_clock);
            n++;
        end
        check_val(tag, 64'(n < 6000), 1);
        repeat (4) @(posedge lpc_clock);
    endtask

    task automatic expect_no_record(input string tag);
        repeat (20) @(posedge lpc_clock);
        #1;
        check_val(tag, uart_tx_led, 0);
    endtask

    // UART decoder: samples mid-bit on falling clock edges.
    initial begin : uart_mon
        int         idx;
        int         last_start;
        logic [7:0] b;
        idx = 0;
        last_start = 0;
        forever begin
            @(negedge lpc_clock);
            if (lpc_reset && uart_tx_pin == 1'b0) begin
                if (idx != 0) check_val("byte_gap", 64'(ncyc - last_start), 10 * DIV);
                last_start = ncyc;
                repeat (DIV / 2) @(negedge lpc_clock);
                check_val("start_bit", uart_tx_pin, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge lpc_clock);
                    b[i] = uart_tx_pin;
                end
                check_val("tx_led_busy", uart_tx_led, 1);
                repeat (DIV) @(negedge lpc_clock);
                check_val("stop_bit", uart_tx_pin, 1);
                if (exp_q.size() == 0) check_val("unexpected_byte", b, 64'h1FF);
                else                   check_val("uart_byte", b, exp_q.pop_front());
                idx = (idx == 5) ? 0 : idx + 1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0]  ty;
        logic        dir;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [3:0]  sync;
        int          nw;
        int          r;
        bit          abort;

        ext_clock = 1'b0;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hF;
        lpc_reset = 1'b1;
        #1 lpc_reset = 1'b0;
        #3;
        check_val("rst_tx_pin", uart_tx_pin, 1);
        check_val("rst_tx_led", uart_tx_led, 0);
        check_val("rst_ovf", overflow_led, 0);
        check_val("rst_frame_led", lpc_frame_led, 0);
        check_val("rst_clock_led", lpc_clock_led, 0);
        check_val("rst_led_low", lpc_reset_led, 1);
        #5 lpc_reset = 1'b1;
        #1 check_val("rst_led_high", lpc_reset_led, 0);
        repeat (3) @(posedge lpc_clock);

        // Non-START nibble with LFRAME# low: frame LED follows, decoder stays idle.
        drive(1'b0, 4'h3);
        @(posedge lpc_clock); #1;
        check_val("frame_led", lpc_frame_led, 1);
        drive(1'b1, 4'hF);
        expect_no_record("bad_start");

        do_cycle(2'b00, 1'b1, 32'h0000_0060, 8'hF1, 0, 4'h0, 1'b0);
        model_push(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
        wait_drain("io_write");

        do_cycle(2'b00, 1'b0, 32'h0000_0060, 8'hF1, 0, 4'h0, 1'b0);
        model_push(2'b00, 1'b0, 32'h0000_0060, 8'hF1);
        wait_drain("io_read");

        do_cycle(2'b01, 1'b0, 32'h1234_5678, 8'hF1, 0, 4'h0, 1'b0);
        model_push(2'b01, 1'b0, 32'h1234_5678, 8'hF1);
        wait_drain("mem_read");

        do_cycle(2'b00, 1'b1, 32'h0000_0080, 8'h55, 0, 4'h0, 1'b1);
        expect_no_record("abort_addr");

        do_cycle(2'b00, 1'b0, 32'h0000_0070, 8'h3C, 3, 4'h0, 1'b0);
        model_push(2'b00, 1'b0, 32'h0000_0070, 8'h3C);
        wait_drain("sync_wait");

        do_cycle(2'b00, 1'b1, 32'h0000_0070, 8'h3C, 0, 4'hA, 1'b0);
        expect_no_record("sync_error");

        for (int t = 0; t < 24; t++) begin
            ty    = 2'($urandom_range(0, 1));
            dir   = 1'($urandom_range(0, 1));
            addr  = (ty == 2'b01) ? $urandom() : ($urandom() & 32'h0000_FFFF);
            data  = 8'($urandom());
            nw    = $urandom_range(0, 3);
            r     = $urandom_range(0, 7);
            abort = (r == 0);
            sync  = (r == 1) ? 4'hA : ((r == 2) ? 4'h3 : 4'h0);
            do_cycle(ty, dir, addr, data, nw, sync, abort);
            if (!abort && sync == 4'h0) begin
                model_push(ty, dir, addr, data);
                wait_drain("rand_drain");
            end else begin
                expect_no_record("rand_norec");
            end
        end

        // Overflow: keep the UART busy, then offer nine records to an eight-deep FIFO.
        do_cycle(2'b00, 1'b1, 32'h0000_0060, 8'hF1, 0, 4'h0, 1'b0);
        model_push(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
        r = 0;
        while (!uart_tx_led && r < 20) begin
            @(posedge lpc_clock);
            r++;
        end
        check_val("ovf_primer_busy", uart_tx_led, 1);
        for (int i = 0; i < 9; i++) begin
            addr = 32'h0000_0100 + 32'(i);
            data = 8'($urandom());
            do_cycle(2'b00, 1'b1, addr, data, 0, 4'h0, 1'b0);
            if (i < 8) model_push(2'b00, 1'b1, addr, data);
            if (i == 7) begin
                @(posedge lpc_clock); #1;
                check_val("ovf_not_yet", overflow_led, 0);
            end
        end
        @(posedge lpc_clock); #1;
        check_val("ovf_set", overflow_led, 1);
        wait_drain("ovf_drain");
        check_val("ovf_sticky", overflow_led, 1);

        lpc_reset = 1'b0;
        #2;
        check_val("ovf_cleared", overflow_led, 0);
        check_val("rst2_led", lpc_reset_led, 1);
        #6 lpc_reset = 1'b1;

        repeat (300) @(posedge lpc_clock);
        check_val("leftover_bytes", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
